y86_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the Y86 SEQ datapath. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, and enables each stage only in its own state. It also runs the instruction- and data-memory request/acknowledge handshakes, holds architectural status (AOK/HLT/ADR/INS) and counts retired instructions. It sits beside the fetch/decode/execute/memory units and drives only their enables.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/y86_icode_class.sv | 20 ++
 rtl/y86_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 SEQ sequencer: instruction codes, status
// encoding, controller states and the instruction-class helper functions.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALTED    = 3'd7
    } state_t;

    function automatic logic is_mem_rd(input logic [3:0] icode);
        return (icode == I_MRMOVL) || (icode == I_RET) || (icode == I_POPL);
    endfunction

    function automatic logic is_mem_wr(input logic [3:0] icode);
        return (icode == I_RMMOVL) || (icode == I_CALL) || (icode == I_PUSHL);
    endfunction

    // NOP, RMMOVL, JXX and HALT never touch the register file.
    function automatic logic writes_reg(input logic [3:0] icode, input logic cnd);
        case (icode)
            I_CMOVXX: return cnd;
            I_IRMOVL, I_MRMOVL, I_OPL, I_CALL,
            I_RET, I_PUSHL, I_POPL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_icode_class.sv
// Combinational class decode of the latched instruction code and condition flag.
module y86_icode_class
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic       cnd_i,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       wb_o,
    output logic       sets_cc_o,
    output logic       legal_o
);

    assign mem_rd_o  = is_mem_rd(icode_i);
    assign mem_wr_o  = is_mem_wr(icode_i);
    assign wb_o      = writes_reg(icode_i, cnd_i);
    assign sets_cc_o = (icode_i == I_OPL);
    assign legal_o   = (icode_i <= I_POPL);

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle SEQ sequencer: walks each instruction through the stages, runs the
// memory handshakes, tracks architectural status and counts retired instructions.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_ack_i,
    input  logic             imem_err_i,
    input  logic             dmem_ack_i,
    input  logic             dmem_err_i,
    input  logic             cnd_i,
    output logic             imem_req_o,
    output logic             dmem_rd_o,
    output logic             dmem_wr_o,
    output logic             dec_en_o,
    output logic             exe_en_o,
    output logic             cc_en_o,
    output logic             wb_en_o,
    output logic             pc_en_o,
    output logic [1:0]       stat_o,
    output logic             running_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_icode;
    logic             r_cnd;
    stat_t            r_stat;
    stat_t            w_haltStat;
    logic [CNT_W-1:0] r_retired;

    logic w_memRd;
    logic w_memWr;
    logic w_wb;
    logic w_setsCc;
    logic w_legal;

    y86_icode_class u_class (
        .icode_i   (r_icode),
        .cnd_i     (r_cnd),
        .mem_rd_o  (w_memRd),
        .mem_wr_o  (w_memWr),
        .wb_o      (w_wb),
        .sets_cc_o (w_setsCc),
        .legal_o   (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_icode   <= 4'h0;
            r_cnd     <= 1'b0;
            r_stat    <= STAT_AOK;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ack_i && !imem_err_i)
                r_icode <= icode_i;
            if (r_state == S_EXECUTE)
                r_cnd <= cnd_i;
            // Status is written once, on the edge that enters HALTED.
            if (w_next == S_HALTED && r_state != S_HALTED)
                r_stat <= w_haltStat;
            if (r_state == S_PCUPD)
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next     = r_state;
        w_haltStat = r_stat;
        imem_req_o = 1'b0;
        dmem_rd_o  = 1'b0;
        dmem_wr_o  = 1'b0;
        dec_en_o   = 1'b0;
        exe_en_o   = 1'b0;
        cc_en_o    = 1'b0;
        wb_en_o    = 1'b0;
        pc_en_o    = 1'b0;
        running_o  = 1'b1;
        case (r_state)
            S_IDLE: begin
                running_o = 1'b0;
                if (start_i)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    if (imem_err_i) begin
                        w_next     = S_HALTED;
                        w_haltStat = STAT_ADR;
                    end else begin
                        w_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                dec_en_o = 1'b1;
                if (!instr_valid_i || !w_legal) begin
                    w_next     = S_HALTED;
                    w_haltStat = STAT_INS;
                end else if (r_icode == I_HALT) begin
                    w_next     = S_HALTED;
                    w_haltStat = STAT_HLT;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                exe_en_o = 1'b1;
                cc_en_o  = w_setsCc;
                w_next   = (w_memRd || w_memWr) ? S_MEMORY : S_WRITEBACK;
            end
            // Read and write classes are disjoint, the guard keeps that explicit.
            S_MEMORY: begin
                dmem_rd_o = w_memRd;
                dmem_wr_o = w_memWr && !w_memRd;
                if (dmem_ack_i) begin
                    if (dmem_err_i) begin
                        w_next     = S_HALTED;
                        w_haltStat = STAT_ADR;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                wb_en_o = w_wb;
                w_next  = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en_o = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALTED: begin
                running_o = 1'b0;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign stat_o    = r_stat;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: directed scenarios plus randomized
// instruction streams scored against a per-instruction timing/strobe model.
module tb_y86_seq_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [3:0]    icode_i;
    logic          instr_valid_i;
    logic          imem_ack_i;
    logic          imem_err_i;
    logic          dmem_ack_i;
    logic          dmem_err_i;
    logic          cnd_i;
    logic          imem_req_o;
    logic          dmem_rd_o;
    logic          dmem_wr_o;
    logic          dec_en_o;
    logic          exe_en_o;
    logic          cc_en_o;
    logic          wb_en_o;
    logic          pc_en_o;
    logic [1:0]    stat_o;
    logic          running_o;
    logic [CW-1:0] retired_o;

    int compared   = 0;
    int mismatched = 0;
    int modelRetired = 0;
    int modelStat    = 0;
    bit lastHalted   = 1'b0;

    always #5 clk = ~clk;

    y86_seq_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .icode_i       (icode_i),
        .instr_valid_i (instr_valid_i),
        .imem_ack_i    (imem_ack_i),
        .imem_err_i    (imem_err_i),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_err_i    (dmem_err_i),
        .cnd_i         (cnd_i),
        .imem_req_o    (imem_req_o),
        .dmem_rd_o     (dmem_rd_o),
        .dmem_wr_o     (dmem_wr_o),
        .dec_en_o      (dec_en_o),
        .exe_en_o      (exe_en_o),
        .cc_en_o       (cc_en_o),
        .wb_en_o       (wb_en_o),
        .pc_en_o       (pc_en_o),
        .stat_o        (stat_o),
        .running_o     (running_o),
        .retired_o     (retired_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] allStrobes();
        return 32'({imem_req_o, dmem_rd_o, dmem_wr_o, dec_en_o, exe_en_o,
                    cc_en_o, wb_en_o, pc_en_o, running_o});
    endfunction

    // Synchronous reset, then confirm acks and errors in IDLE are ignored.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0; imem_ack_i = 1'b0; imem_err_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelRetired = 0;
        modelStat    = 0;
        checkOutput("reset/strobes", allStrobes(), 32'd0);
        checkOutput("reset/stat", 32'(stat_o), 32'd0);
        checkOutput("reset/retired", 32'(retired_o), 32'd0);
        @(negedge clk);
        imem_ack_i = 1'b1; imem_err_i = 1'b1; dmem_ack_i = 1'b1; dmem_err_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle/ack_ignored", allStrobes(), 32'd0);
        checkOutput("idle/stat", 32'(stat_o), 32'd0);
        imem_ack_i = 1'b0; imem_err_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    endtask

    task automatic startRun();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        checkOutput("start/fetch", 32'({running_o, imem_req_o}), 32'd3);
    endtask

    // Runs one instruction from its first FETCH cycle; the model predicts its length
    // and how many cycles each strobe is high, then the state right afterwards.
    task automatic applyStimulus(input string tag, input logic [3:0] ic, input logic valid,
                                 input int iw, input logic ie, input int dw, input logic de,
                                 input logic c);
        bit isRd, isWr, isMem, proceed, memFail, retires, writes;
        int n, expStat;
        int cReq, cRd, cWr, cBoth, cDec, cExe, cCc, cWb, cPc, cRun;
        isRd    = ic inside {4'h5, 4'h9, 4'hB};
        isWr    = ic inside {4'h4, 4'h8, 4'hA};
        isMem   = isRd || isWr;
        proceed = !ie && valid && (ic <= 4'hB) && (ic != 4'h0);
        memFail = proceed && isMem && de;
        retires = proceed && !memFail;
        writes  = (ic == 4'h2) ? c : (ic inside {4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB});
        n = iw + 1;
        if (!ie) begin
            n += 1;
            if (proceed) n += 1 + (isMem ? dw + 1 : 0) + (memFail ? 0 : 2);
        end
        expStat = modelStat;
        if (ie) expStat = 2;
        else if (!valid || ic > 4'hB) expStat = 3;
        else if (ic == 4'h0) expStat = 1;
        else if (memFail) expStat = 2;
        {cReq, cRd, cWr, cBoth, cDec, cExe, cCc, cWb, cPc, cRun} = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (imem_req_o) cReq++;
            if (dmem_rd_o) cRd++;
            if (dmem_wr_o) cWr++;
            if (dmem_rd_o && dmem_wr_o) cBoth++;
            if (dec_en_o) cDec++;
            if (exe_en_o) cExe++;
            if (cc_en_o) cCc++;
            if (wb_en_o) cWb++;
            if (pc_en_o) cPc++;
            if (running_o) cRun++;
            instr_valid_i = valid;
            start_i = 1'($urandom);
            if (imem_req_o) begin
                imem_ack_i = (cReq - 1 == iw);
                imem_err_i = (cReq - 1 == iw) ? ie : 1'($urandom);
                icode_i    = ic;
            end else begin
                imem_ack_i = 1'($urandom);
                imem_err_i = 1'($urandom);
                icode_i    = 4'($urandom);
            end
            if (dmem_rd_o || dmem_wr_o) begin
                dmem_ack_i = (cRd + cWr - 1 == dw);
                dmem_err_i = (cRd + cWr - 1 == dw) ? de : 1'($urandom);
            end else begin
                dmem_ack_i = 1'($urandom);
                dmem_err_i = 1'($urandom);
            end
            cnd_i = exe_en_o ? c : 1'($urandom);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        if (retires) modelRetired++;
        modelStat  = expStat;
        lastHalted = !retires;
        checkOutput($sformatf("%s/req_cycles", tag), 32'(cReq), 32'(iw + 1));
        checkOutput($sformatf("%s/dec", tag), 32'(cDec), 32'(ie ? 0 : 1));
        checkOutput($sformatf("%s/exe", tag), 32'(cExe), 32'(proceed));
        checkOutput($sformatf("%s/cc", tag), 32'(cCc), 32'(proceed && ic == 4'h6));
        checkOutput($sformatf("%s/rd_cycles", tag), 32'(cRd), 32'((proceed && isRd) ? dw + 1 : 0));
        checkOutput($sformatf("%s/wr_cycles", tag), 32'(cWr), 32'((proceed && isWr) ? dw + 1 : 0));
        checkOutput($sformatf("%s/rd_wr_both", tag), 32'(cBoth), 32'd0);
        checkOutput($sformatf("%s/wb", tag), 32'(cWb), 32'(retires && writes));
        checkOutput($sformatf("%s/pc", tag), 32'(cPc), 32'(retires));
        checkOutput($sformatf("%s/running", tag), 32'(cRun), 32'(n));
        checkOutput($sformatf("%s/after_run_req", tag), 32'({running_o, imem_req_o}),
                    retires ? 32'd3 : 32'd0);
        checkOutput($sformatf("%s/stat", tag), 32'(stat_o), 32'(modelStat));
        checkOutput($sformatf("%s/retired", tag), 32'(retired_o), 32'(modelRetired % (1 << CW)));
    endtask

    // HALTED must absorb start pulses and acks while holding stat and count.
    task automatic checkHalted(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            start_i    = 1'($urandom);
            imem_ack_i = 1'b1; imem_err_i = 1'($urandom);
            dmem_ack_i = 1'b1; dmem_err_i = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("halted/strobes", allStrobes(), 32'd0);
            checkOutput("halted/stat", 32'(stat_o), 32'(modelStat));
            checkOutput("halted/retired", 32'(retired_o), 32'(modelRetired % (1 << CW)));
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; icode_i = 4'h0; instr_valid_i = 1'b1;
        imem_ack_i = 1'b0; imem_err_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
        cnd_i = 1'b0;

        doReset();
        startRun();
        applyStimulus("nop",      4'h1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("mrmovl",   4'h5, 1'b1, 0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus("cmov_c0",  4'h2, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("cmov_c1",  4'h2, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus("opl_wait", 4'h6, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("rmmovl",   4'h4, 1'b1, 1, 1'b0, 1, 1'b0, 1'b1);
        applyStimulus("jxx",      4'h7, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus("halt",     4'h0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        checkHalted(4);

        doReset(); startRun();
        applyStimulus("bad_icode", 4'hC, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        checkHalted(2);
        doReset(); startRun();
        applyStimulus("pushl_err", 4'hA, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0);
        checkHalted(2);
        doReset(); startRun();
        applyStimulus("invalid", 4'h6, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        checkHalted(2);
        doReset(); startRun();
        applyStimulus("imem_err", 4'h1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0);
        checkHalted(2);

        // Reset while a PUSHL write request is outstanding.
        doReset(); startRun();
        applyStimulus("opl", 4'h6, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus("call", 4'h8, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b0; imem_ack_i = 1'b1; imem_err_i = 1'b0; icode_i = 4'hA;
        instr_valid_i = 1'b1; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
        @(negedge clk); imem_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmem/wr_req", 32'({dmem_wr_o, dmem_rd_o}), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        modelRetired = 0; modelStat = 0;
        checkOutput("rstmem/strobes", allStrobes(), 32'd0);
        checkOutput("rstmem/retired", 32'(retired_o), 32'd0);
        checkOutput("rstmem/stat", 32'(stat_o), 32'd0);
        @(negedge clk); dmem_ack_i = 1'b1;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        checkOutput("rstmem/late_ack", allStrobes(), 32'd0);

        // Long error-free stream so the narrow retired counter wraps.
        startRun();
        for (int i = 0; i < 20; i++)
            applyStimulus("wrap", 4'($urandom_range(1, 11)), 1'b1, $urandom_range(0, 2), 1'b0,
                          $urandom_range(0, 2), 1'b0, 1'($urandom));

        doReset(); startRun();
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [3:0] ic;
            r = $urandom_range(0, 31);
            if (r == 0) ic = 4'h0;
            else if (r < 3) ic = 4'($urandom_range(12, 15));
            else ic = 4'($urandom_range(1, 11));
            applyStimulus("rand", ic, 1'($urandom_range(0, 31) != 0), $urandom_range(0, 3),
                          1'($urandom_range(0, 39) == 0), $urandom_range(0, 3),
                          1'($urandom_range(0, 19) == 0), 1'($urandom));
            if (lastHalted) begin
                checkHalted(2);
                doReset();
                startRun();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
